m_ex_sequencer: RTL
===================

M_EX_SEQUENCER -- requirements
Module: m_ex_sequencer

Interface
REQ-001 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  M-op offered by ID/EX.
- issue_ready_o  out  1  sequencer accepts op.
- rs1_data_i  in  32  operand 1.
- rs2_data_i  in  32  operand 2.
- funct3_i  in  m_funct3  operation.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  kill in-flight op.
- alu_active_o  out  1  drives m_alu_active of the M-extension ALU.
- alu_rs1_o  out  32  latched rs1 to the ALU.
- alu_rs2_o  out  32  latched rs2 to the ALU.
- alu_funct3_o  out  m_funct3  latched funct3 to the ALU.
- alu_done_i  in  1  ALU done.
- alu_rd_data_i  in  32  ALU result.
- wb_valid_o  out  1  result available to MEM/WB.
- wb_ready_i  in  1  MEM/WB accepts.
- wb_rd_addr_o  out  5  result destination.
- wb_data_o  out  32  result.
- stall_o  out  1  upstream must hold.

Function
REQ-002 SHALL implement FSM states IDLE, BUSY and HOLD.
REQ-003 SHALL assert issue_ready_o = (state==IDLE) | (state==HOLD & wb_ready_i) & ~flush_i.
REQ-004 SHALL accept (fire) an op when issue_valid_i & issue_ready_o, latching rs1, rs2, funct3 and rd into operand registers on that edge.
REQ-005 SHALL detect special cases combinationally at fire:
- div/divu with rs2==0: result 0xFFFF_FFFF.
- rem/remu with rs2==0: result rs1.
- div with rs1==0x8000_0000 and rs2==0xFFFF_FFFF: result 0x8000_0000.
- rem with the same operands: result 0.
REQ-006 SHALL, on fire of a special case, load the result register and go directly to HOLD with zero ALU cycles; alu_active_o stays 0.
REQ-007 SHALL, on fire with rd_addr_i==0, discard the op: return to or stay in IDLE with no wb_valid_o and no ALU activation.
REQ-008 SHALL, on any other fire, go to BUSY; alu_active_o=1 exactly while in BUSY.
REQ-009 SHALL ignore alu_done_i outside BUSY, because the ALU reports done while inactive.
REQ-010 SHALL, in BUSY with alu_done_i=1, capture alu_rd_data_i into the result register and go to HOLD.
REQ-011 SHALL hold wb_valid_o=1 in HOLD only, with wb_data_o and wb_rd_addr_o stable until wb_ready_i.
REQ-012 SHALL leave HOLD on wb_ready_i: to IDLE, or straight to a new op's next state if a fire occurs in the same cycle (back-to-back issue).
REQ-013 SHALL, when flush_i=1, force state IDLE on the next edge from any state: drop the result and deassert alu_active_o and wb_valid_o; flush wins over a simultaneous fire or alu_done_i.
REQ-014 SHALL drive stall_o = issue_valid_i & ~issue_ready_o.
REQ-015 SHALL hold the alu_rs1_o, alu_rs2_o and alu_funct3_o values constant throughout BUSY.

Reset
REQ-016 SHALL, on rst low, asynchronously enter IDLE and clear the operand, result and rd registers to 0; outputs issue_ready_o=1, alu_active_o=0, wb_valid_o=0, stall_o=issue_valid_i.
REQ-017 SHALL abandon an in-flight ALU op on reset mid-BUSY, with no residual wb_valid_o after reset deasserts.

Structure
REQ-018 SHALL place the state enum (seq_state_t) and the constants DIV0_QUOTIENT=0xFFFF_FFFF and INT32_MIN=0x8000_0000 in the shared m_extension package alongside m_funct3.
REQ-019 SHALL implement special-case detection and result selection as one combinational sub-module named m_ex_special_case.
REQ-020 SHALL fit within 120-400 lines of RTL, excluding the package.

Verification
REQ-021 SHALL cover the following directed scenarios:
- mul with rs1=7, rs2=6, rd=5; ALU done after 3 BUSY cycles -> one wb_valid_o pulse, wb_data_o=42, wb_rd_addr_o=5, alu_active_o high for exactly 3 cycles.
- divu with rs1=100, rs2=0, rd=3 -> HOLD one cycle after fire, wb_data_o=0xFFFF_FFFF, alu_active_o never high; rem with rs1=0x8000_0000, rs2=0xFFFF_FFFF -> wb_data_o=0.
- wb_ready_i=0 for 4 HOLD cycles, then 1 with a new issue_valid_i in the same cycle -> data stable for all 4 cycles, stall_o=1, new op fires on the release cycle.
- flush_i asserted in the second BUSY cycle together with alu_done_i -> IDLE next cycle, no wb_valid_o.
- rst pulsed low mid-BUSY -> all outputs at reset values immediately (asynchronous), no writeback afterwards.
- div with rd=0 -> no wb_valid_o, alu_active_o stays 0, issue_ready_o stays 1.

Source files
------------

// File: rtl/m_extension_pkg.sv
// m_extension_pkg: shared M-extension types and constants (funct3 encoding, sequencer states, special results)
package m_extension_pkg;
  typedef enum logic [2:0] {
    F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU
  } m_funct3;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} seq_state_t;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
endpackage

// File: rtl/m_ex_special_case.sv
// m_ex_special_case: flags M-ops whose result is known without running the ALU, and supplies that result
// Ports: rs1_i/rs2_i/funct3_i = offered op; special_o = op needs no ALU; result_o = its architectural result
module m_ex_special_case
  import m_extension_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  m_funct3     funct3_i,
  output logic        special_o,
  output logic [31:0] result_o
);
  logic is_div, is_rem, div0, ovf;
  assign is_div    = (funct3_i == F_DIV) | (funct3_i == F_DIVU);
  assign is_rem    = (funct3_i == F_REM) | (funct3_i == F_REMU);
  assign div0      = rs2_i == '0;
  // Signed overflow only exists for the signed variants
  assign ovf       = ((funct3_i == F_DIV) | (funct3_i == F_REM)) & (rs1_i == INT32_MIN) & (rs2_i == DIV0_QUOTIENT);
  assign special_o = (is_div | is_rem) & (div0 | ovf);
  assign result_o  = div0 ? (is_div ? DIV0_QUOTIENT : rs1_i) : (is_div ? INT32_MIN : '0);
endmodule

// File: rtl/m_ex_sequencer.sv
// m_ex_sequencer: issues one M-op at a time to the M-extension ALU and holds its result for MEM/WB
// Ports: issue_* = op handshake from ID/EX; alu_* = operands/control to and result from the ALU;
//        wb_* = result handshake to MEM/WB; flush_i kills the in-flight op; stall_o holds upstream
module m_ex_sequencer
  import m_extension_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  m_funct3     funct3_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        alu_active_o,
  output logic [31:0] alu_rs1_o,
  output logic [31:0] alu_rs2_o,
  output m_funct3     alu_funct3_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_rd_data_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        stall_o
);
  seq_state_t  state_q, state_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
  m_funct3     funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        fire, latch, special, alu_fin;
  logic [31:0] special_result;
  m_ex_special_case u_special (
    .rs1_i     (rs1_data_i),
    .rs2_i     (rs2_data_i),
    .funct3_i  (funct3_i),
    .special_o (special),
    .result_o  (special_result)
  );
  assign fire    = issue_valid_i & issue_ready_o;
  assign latch   = fire & ~flush_i;
  assign alu_fin = (state_q == S_BUSY) & alu_done_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end
  // Flush beats everything; a fire out of HOLD skips IDLE entirely
  always_comb begin
    state_d = flush_i ? S_IDLE :
              fire ? ((rd_addr_i == '0) ? S_IDLE : special ? S_HOLD : S_BUSY) :
              alu_fin ? S_HOLD :
              ((state_q == S_HOLD) & wb_ready_i) ? S_IDLE : state_q;
  end
  always_comb begin
    issue_ready_o = (state_q == S_IDLE) | ((state_q == S_HOLD) & wb_ready_i & ~flush_i);
    stall_o       = issue_valid_i & ~issue_ready_o;
    alu_active_o  = state_q == S_BUSY;
    wb_valid_o    = state_q == S_HOLD;
    alu_rs1_o     = rs1_q;
    alu_rs2_o     = rs2_q;
    alu_funct3_o  = funct3_q;
    wb_rd_addr_o  = rd_q;
    wb_data_o     = result_q;
  end
  // Operands only move on fire, which cannot happen in BUSY, so they stay put for the whole ALU run
  always_comb begin
    rs1_d    = latch ? rs1_data_i : rs1_q;
    rs2_d    = latch ? rs2_data_i : rs2_q;
    funct3_d = latch ? funct3_i : funct3_q;
    rd_d     = latch ? rd_addr_i : rd_q;
    result_d = (latch & special) ? special_result : alu_fin ? alu_rd_data_i : result_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= F_MUL;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end
endmodule
